fe_power_sequencer: RTL
=======================

// Module: fe_power_sequencer
// PURPOSE
//  Sequences the front-end voltage-regulator enables EN[N_CH-1:0] with staggered turn-on/turn-off.
//  Monitors the per-channel over-current flags OC[N_CH-1:0] and trips all channels on a filtered fault.
//  Sits between the power GPIO control bits (CH_MASK, POWER_ON/OFF strobes) and the EN/OC board pins, in the BUS_CLK domain.
// PARAMETERS
//  N_CH          4       number of regulator channels
//  STEP_CYCLES   48000   BUS_CLK cycles between successive channel enable/disable (1 ms at 48 MHz)
//  SETTLE_CYCLES 480000  wait after last channel enabled before READY (10 ms)
//  OC_BLANK      96000   cycles after a channel's EN rises during which its OC is ignored (inrush)
//  OC_FILTER     16      consecutive synchronized OC-high cycles required to declare a fault
// PORTS
//  BUS_CLK     in   1      clock
//  BUS_RST     in   1      asynchronous reset, active-high
//  CH_MASK     in   N_CH   channels to power; sampled only on an accepted POWER_ON
//  POWER_ON    in   1      single-cycle start strobe
//  POWER_OFF   in   1      single-cycle stop strobe
//  FAULT_CLEAR in   1      single-cycle strobe; leaves TRIP
//  OC          in   N_CH   asynchronous over-current flags, active-high
//  EN          out  N_CH   regulator enables, registered
//  READY       out  1      all masked channels on and settled
//  BUSY        out  1      high in RAMP_UP, RAMP_DOWN
//  FAULT       out  N_CH   sticky per-channel fault flags
//  STATE       out  3      current FSM state, for status readback
// BEHAVIOUR
//  Reset: EN=0, READY=0, BUSY=0, FAULT=0, STATE=OFF, all counters 0.
//  States: OFF=0, RAMP_UP=1, ON=2, RAMP_DOWN=3, TRIP=4.
//  OFF:
//   - POWER_ON with CH_MASK!=0: latch mask, enter RAMP_UP.
//   - The lowest masked EN bit is set on the next edge (latency 1).
//   - POWER_ON with CH_MASK==0 is ignored.
//  RAMP_UP:
//   - One further masked channel is enabled, in ascending index order, every STEP_CYCLES.
//   - After the last channel: wait SETTLE_CYCLES, then enter ON with READY=1.
//  ON:
//   - READY=1.
//   - POWER_ON is ignored.
//   - POWER_OFF enters RAMP_DOWN; READY drops on the next edge.
//  RAMP_DOWN:
//   - Highest enabled channel cleared on the first edge.
//   - Next lower channel cleared every STEP_CYCLES.
//   - Enter OFF when EN==0.
//   - A POWER_OFF during RAMP_UP aborts it and enters RAMP_DOWN from the highest currently enabled channel.
//  Same-cycle POWER_ON and POWER_OFF: POWER_OFF wins.
//  OC path:
//   - 2-FF synchronizer per channel.
//   - Consecutive-high counter; any low sample clears it.
//   - Counter held at 0 while EN[i]=0 or within OC_BLANK cycles of EN[i] rising.
//   - Counter reaching OC_FILTER sets FAULT[i].
//  Fault in RAMP_UP, ON or RAMP_DOWN:
//   - All EN clear on the next edge (no stagger).
//   - READY=0; enter TRIP.
//   - Several channels faulting in the same cycle all set their FAULT bits.
//  TRIP:
//   - POWER_ON and POWER_OFF are ignored.
//   - FAULT_CLEAR clears FAULT and the filter counters and enters OFF.
//   - FAULT_CLEAR outside TRIP has no effect.
//  Counters: width $clog2(max+1), saturating, reloaded on every state transition.
//  BUS_RST mid-ramp: EN drops immediately (async); no sequenced shutdown.
// STRUCTURE
//  Package fe_power_pkg: state encodings (localparams), STATE width.
//  Sub-module fe_oc_filter (synchronizer, blank counter, filter counter, fault pulse), generated N_CH times.
//  Top module holds FSM, step/settle counter, latched mask.
// TESTING
//  Bench parameters: N_CH=4, STEP_CYCLES=4, SETTLE_CYCLES=5, OC_BLANK=2, OC_FILTER=3.
//  1. Power-up:
//     - POWER_ON, CH_MASK=4'b1011 at cycle 0.
//     - EN=0001@1, 0011@5, 1011@9; READY=1@14.
//  2. Power-down:
//     - From ON, POWER_OFF.
//     - EN=0011@+1, 0001@+5, 0000@+9; STATE=OFF.
//  3. Fault trip:
//     - ON with mask 1111; OC[2] high 3 cycles (after sync) -> FAULT=0100, EN=0000 next edge, STATE=TRIP.
//     - POWER_ON ignored; FAULT_CLEAR -> FAULT=0, STATE=OFF.
//  4. Blanking and glitch filter:
//     - OC[0] high during first 2 cycles after EN[0] rises -> no fault.
//     - Later 2-cycle OC[0] pulse -> no fault.
//  5. Abort and conflicts:
//     - POWER_OFF at cycle 6 of test 1 -> RAMP_DOWN; EN=0001@7, 0000@11.
//     - POWER_ON+POWER_OFF same cycle in OFF -> stays OFF.
//     - POWER_ON with mask 0 -> stays OFF.
//  6. Reset mid-ramp: BUS_RST asserted in RAMP_UP -> EN=0, FAULT=0, STATE=OFF without a clock edge.

Source files
------------

// File: rtl/fe_power_pkg.sv
// Shared definitions for the front-end power sequencer: FSM state
// encodings and the width of the STATE readback port.
package fe_power_pkg;

   localparam int STATE_W = 3;

   localparam logic [STATE_W-1:0] ST_OFF       = 3'd0;
   localparam logic [STATE_W-1:0] ST_RAMP_UP   = 3'd1;
   localparam logic [STATE_W-1:0] ST_ON        = 3'd2;
   localparam logic [STATE_W-1:0] ST_RAMP_DOWN = 3'd3;
   localparam logic [STATE_W-1:0] ST_TRIP      = 3'd4;

endpackage

// File: rtl/fe_oc_filter.sv
// Per-channel over-current qualifier. Synchronizes the raw board flag,
// ignores it while the channel is off or still inside its inrush window,
// and reports a fault once the flag has been high for OC_FILTER
// consecutive qualified cycles.
module fe_oc_filter #(
   parameter int OC_BLANK  = 96000,
   parameter int OC_FILTER = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   input  logic oc,
   output logic fault_pulse
);

   localparam int BW = (OC_BLANK > 0) ? $clog2(OC_BLANK + 1) : 1;
   localparam int FW = $clog2(OC_FILTER + 1);

   logic          oc_meta;
   logic          oc_sync;
   logic [BW-1:0] blank_cnt;
   logic [FW-1:0] filt_cnt;
   logic          qualified;

   // Two-flop synchronizer for the asynchronous over-current flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         oc_meta <= 1'b0;
         oc_sync <= 1'b0;
      end else begin
         oc_meta <= oc;
         oc_sync <= oc_meta;
      end
   end

   // Counts cycles since the enable rose; saturates once inrush is over.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         blank_cnt <= '0;
      end else if (!en) begin
         blank_cnt <= '0;
      end else if (blank_cnt != BW'(OC_BLANK)) begin
         blank_cnt <= blank_cnt + BW'(1);
      end
   end

   assign qualified = en && (blank_cnt == BW'(OC_BLANK));

   // Consecutive-high counter; any low or unqualified sample restarts it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         filt_cnt <= '0;
      end else if (clr || !qualified || !oc_sync) begin
         filt_cnt <= '0;
      end else if (filt_cnt != FW'(OC_FILTER)) begin
         filt_cnt <= filt_cnt + FW'(1);
      end
   end

   assign fault_pulse = (filt_cnt == FW'(OC_FILTER));

endmodule

// File: rtl/fe_power_sequencer.sv
// Front-end regulator sequencer. Staggers the channel enables up and
// down, waits for the rails to settle before reporting READY, and drops
// every rail at once when a filtered over-current fault is seen.
module fe_power_sequencer
   import fe_power_pkg::*;
#(
   parameter int N_CH          = 4,
   parameter int STEP_CYCLES   = 48000,
   parameter int SETTLE_CYCLES = 480000,
   parameter int OC_BLANK      = 96000,
   parameter int OC_FILTER     = 16
) (
   input  logic               BUS_CLK,
   input  logic               BUS_RST,
   input  logic [N_CH-1:0]    CH_MASK,
   input  logic               POWER_ON,
   input  logic               POWER_OFF,
   input  logic               FAULT_CLEAR,
   input  logic [N_CH-1:0]    OC,
   output logic [N_CH-1:0]    EN,
   output logic               READY,
   output logic               BUSY,
   output logic [N_CH-1:0]    FAULT,
   output logic [STATE_W-1:0] STATE
);

   localparam int CNT_MAX = (STEP_CYCLES > SETTLE_CYCLES) ? STEP_CYCLES : SETTLE_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] STEP_LAST   = CNT_W'(STEP_CYCLES - 1);
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

   logic [STATE_W-1:0] state, state_nxt;
   logic [N_CH-1:0]    en_q, en_nxt;
   logic [N_CH-1:0]    mask_q, mask_nxt;
   logic [N_CH-1:0]    fault_q, fault_nxt;
   logic [CNT_W-1:0]   cnt, cnt_nxt;
   logic [N_CH-1:0]    fault_pulse;
   logic               filt_clr;

   // Isolates the lowest set bit: the next channel to bring up.
   function automatic logic [N_CH-1:0] lowest_bit(input logic [N_CH-1:0] v);
      logic [N_CH-1:0] r;
      logic            found;
      r     = '0;
      found = 1'b0;
      for (int i = 0; i < N_CH; i++) begin
         if (!found && v[i]) begin
            r[i]  = 1'b1;
            found = 1'b1;
         end
      end
      return r;
   endfunction

   // Clears the highest set bit: the next channel to take down.
   function automatic logic [N_CH-1:0] clear_highest(input logic [N_CH-1:0] v);
      logic [N_CH-1:0] r;
      logic            found;
      r     = v;
      found = 1'b0;
      for (int i = N_CH - 1; i >= 0; i--) begin
         if (!found && v[i]) begin
            r[i]  = 1'b0;
            found = 1'b1;
         end
      end
      return r;
   endfunction

   assign filt_clr = (state == ST_TRIP) && FAULT_CLEAR;

   for (genvar i = 0; i < N_CH; i++) begin : g_oc
      fe_oc_filter #(
         .OC_BLANK  (OC_BLANK),
         .OC_FILTER (OC_FILTER)
      ) u_filt (
         .clk         (BUS_CLK),
         .rst         (BUS_RST),
         .en          (en_q[i]),
         .clr         (filt_clr),
         .oc          (OC[i]),
         .fault_pulse (fault_pulse[i])
      );
   end

   // Next-state logic: sequencing, abort, trip and recovery decisions.
   always_comb begin
      state_nxt = state;
      en_nxt    = en_q;
      mask_nxt  = mask_q;
      fault_nxt = fault_q;
      cnt_nxt   = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + CNT_W'(1);

      case (state)
         ST_OFF: begin
            if (!POWER_OFF && POWER_ON && (CH_MASK != '0)) begin
               state_nxt = ST_RAMP_UP;
               mask_nxt  = CH_MASK;
               en_nxt    = lowest_bit(CH_MASK);
            end
         end
         ST_RAMP_UP: begin
            if (fault_pulse != '0) begin
               state_nxt = ST_TRIP;
               en_nxt    = '0;
               fault_nxt = fault_q | fault_pulse;
            end else if (POWER_OFF) begin
               state_nxt = ST_RAMP_DOWN;
               en_nxt    = clear_highest(en_q);
            end else if (en_q == mask_q) begin
               if (cnt == SETTLE_LAST) begin
                  state_nxt = ST_ON;
               end
            end else if (cnt == STEP_LAST) begin
               en_nxt  = en_q | lowest_bit(mask_q & ~en_q);
               cnt_nxt = '0;
            end
         end
         ST_ON: begin
            if (fault_pulse != '0) begin
               state_nxt = ST_TRIP;
               en_nxt    = '0;
               fault_nxt = fault_q | fault_pulse;
            end else if (POWER_OFF) begin
               state_nxt = ST_RAMP_DOWN;
               en_nxt    = clear_highest(en_q);
            end
         end
         ST_RAMP_DOWN: begin
            if (fault_pulse != '0) begin
               state_nxt = ST_TRIP;
               en_nxt    = '0;
               fault_nxt = fault_q | fault_pulse;
            end else if (cnt == STEP_LAST) begin
               en_nxt  = clear_highest(en_q);
               cnt_nxt = '0;
            end
         end
         ST_TRIP: begin
            if (FAULT_CLEAR) begin
               state_nxt = ST_OFF;
               fault_nxt = '0;
            end
         end
         default: begin
            state_nxt = ST_OFF;
            en_nxt    = '0;
         end
      endcase

      if ((state_nxt == ST_RAMP_DOWN) && (en_nxt == '0)) begin
         state_nxt = ST_OFF;
      end

      if (state_nxt != state) begin
         cnt_nxt = '0;
      end
   end

   // State, enables, latched mask, sticky faults and the step/settle counter.
   always_ff @(posedge BUS_CLK or posedge BUS_RST) begin
      if (BUS_RST) begin
         state   <= ST_OFF;
         en_q    <= '0;
         mask_q  <= '0;
         fault_q <= '0;
         cnt     <= '0;
      end else begin
         state   <= state_nxt;
         en_q    <= en_nxt;
         mask_q  <= mask_nxt;
         fault_q <= fault_nxt;
         cnt     <= cnt_nxt;
      end
   end

   assign EN    = en_q;
   assign FAULT = fault_q;
   assign STATE = state;
   assign READY = (state == ST_ON);
   assign BUSY  = (state == ST_RAMP_UP) || (state == ST_RAMP_DOWN);

endmodule
